timer_counter: RTL and testbench



---
 rtl/timer_counter_if.sv | 11 +
 rtl/timer_counter.sv | 118 +++++++++++
 tb/tb_timer_counter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/timer_counter_if.sv
// rtl/timer_counter_if.sv - register bus between the system bridge and one timer instance
interface timer_counter_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, we, wdata, input rdata, irq);
  modport slave  (input addr, we, wdata, output rdata, irq);
endinterface

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - 32-bit down-counting timer with one-shot/periodic modes and maskable irq
module timer_counter (
  input  logic           clk,
  input  logic           reset_n,
  timer_counter_if.slave bus
);
  localparam logic [1:0] RESET_STATE = 2'd0;
  localparam logic [1:0] ST_LOAD     = 2'd1;
  localparam logic [1:0] ST_CNT      = 2'd2;
  localparam logic [1:0] ST_INT      = 2'd3;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        enable_q, enable_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        int_flag_q, int_flag_d;
  logic        irq_q, irq_d;

  logic        fsm_set, fsm_clr, cpu_ctrl_wr, cpu_preset_wr;

  assign cpu_ctrl_wr   = bus.we && (bus.addr == A_CTRL);
  assign cpu_preset_wr = bus.we && (bus.addr == A_PRESET);

  always_comb begin
    state_d    = state_q;
    enable_d   = enable_q;
    mode_d     = mode_q;
    im_d       = im_q;
    preset_d   = preset_q;
    count_d    = count_q;
    int_flag_d = int_flag_q;
    fsm_set    = 1'b0;
    fsm_clr    = 1'b0;

    case (state_q)
      RESET_STATE: begin
        if (enable_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!enable_q) begin
          state_d = RESET_STATE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = 32'd0;
          fsm_set = 1'b1;
          state_d = ST_INT;
        end
      end
      default: begin
        if (mode_q == 2'd1) begin
          fsm_clr = 1'b1;
          state_d = ST_LOAD;
        end else begin
          enable_d = 1'b0;
          state_d  = RESET_STATE;
        end
      end
    endcase

    // CPU writes land after the FSM so a CTRL write overrides the one-shot Enable clear
    if (cpu_ctrl_wr) begin
      enable_d = bus.wdata[0];
      mode_d   = bus.wdata[2:1];
      im_d     = bus.wdata[3];
    end
    if (cpu_preset_wr) preset_d = bus.wdata;

    if (cpu_ctrl_wr || cpu_preset_wr || fsm_clr) int_flag_d = 1'b0;
    if (fsm_set) int_flag_d = 1'b1;

    irq_d = int_flag_d & im_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RESET_STATE;
      enable_q   <= 1'b0;
      mode_q     <= 2'd0;
      im_q       <= 1'b0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      int_flag_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      im_q       <= im_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      int_flag_q <= int_flag_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    bus.rdata = 32'd0;
    case (bus.addr)
      A_CTRL:   bus.rdata = {28'd0, im_q, mode_q, enable_q};
      A_PRESET: bus.rdata = preset_q;
      A_COUNT:  bus.rdata = count_q;
      default:  bus.rdata = 32'd0;
    endcase
  end

  assign bus.irq = irq_q;
endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - directed and random stimulus against a timeline model of the timer
module tb_timer_counter;
  logic clk;
  logic reset_n;
  timer_counter_if bus();

  timer_counter u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int vecs;
  int errs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Timeline model: a run is described by its load edge and its expiry edge,
  // and COUNT is derived arithmetically from the current edge number.
  longint      e_now, m_load, m_exp;
  bit          m_idle, m_en, m_im, m_flag;
  logic [1:0]  m_mode;
  logic [31:0] m_preset, m_n, m_frozen;

  function automatic logic [31:0] m_count();
    if (m_idle || e_now < m_load) return m_frozen;
    if (e_now < m_exp) return m_n - 32'(e_now - m_load);
    return 32'd0;
  endfunction

  task automatic m_reset();
    e_now = 0; m_load = 0; m_exp = 0;
    m_idle = 1; m_en = 0; m_im = 0; m_flag = 0;
    m_mode = 0; m_preset = 0; m_n = 0; m_frozen = 0;
  endtask

  task automatic m_step(input bit we, input logic [1:0] a, input logic [31:0] wd);
    longint e;
    bit set_f, clr_f, en_n;
    e = e_now + 1;
    set_f = 0; clr_f = 0; en_n = m_en;
    if (m_idle) begin
      if (m_en) begin
        m_idle = 0;
        m_load = e + 1;
      end
    end else if (e == m_load) begin
      m_n = m_preset;
      m_exp = e + ((m_n == 0) ? 1 : longint'(m_n));
    end else if (e <= m_exp) begin
      if (!m_en) begin
        m_frozen = m_n - 32'(e - 1 - m_load);
        m_idle = 1;
      end else if (e == m_exp) begin
        set_f = 1;
      end
    end else begin
      m_frozen = 0;
      if (m_mode == 2'd1) begin
        m_load = e + 1;
        clr_f = 1;
      end else begin
        en_n = 0;
        m_idle = 1;
      end
    end
    if (we && a == 2'd0) begin
      en_n = wd[0]; m_mode = wd[2:1]; m_im = wd[3]; clr_f = 1;
    end
    if (we && a == 2'd1) begin
      m_preset = wd; clr_f = 1;
    end
    m_en = en_n;
    if (clr_f) m_flag = 0;
    if (set_f) m_flag = 1;
    e_now = e;
  endtask

  logic [31:0] obs [4];
  logic        obs_irq;

  task automatic sample_all(input logic [31:0] e0, e1, e2, input logic e_irq);
    for (int a = 0; a < 4; a++) begin
      bus.addr = 2'(a);
      #1;
      obs[a] = bus.rdata;
    end
    obs_irq = bus.irq;
    chk("rd_ctrl", obs[0], e0);
    chk("rd_preset", obs[1], e1);
    chk("rd_count", obs[2], e2);
    chk("rd_rsvd", obs[3], 32'd0);
    chk("irq", {31'd0, obs_irq}, {31'd0, e_irq});
  endtask

  task automatic tick(input bit we, input logic [1:0] a, input logic [31:0] wd);
    bus.we = we; bus.addr = a; bus.wdata = wd;
    @(posedge clk);
    m_step(we, a, wd);
    @(negedge clk);
    bus.we = 1'b0;
    sample_all({28'd0, m_im, m_mode, m_en}, m_preset, m_count(), m_flag & m_im);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    m_reset();
    sample_all(32'd0, 32'd0, 32'd0, 1'b0);
    reset_n = 1'b1;
  endtask

  task automatic wait_irq(input int max, output int n);
    n = 0;
    do begin
      tick(0, 2'd0, 32'd0);
      n++;
    end while (!obs_irq && n < max);
    chk("irq_seen", {31'd0, obs_irq}, 32'd1);
  endtask

  int n;
  int r;
  bit hit;

  initial begin
    vecs = 0; errs = 0;
    bus.we = 0; bus.addr = 0; bus.wdata = 0;
    reset_n = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();
    tick(0, 2'd0, 32'd0);

    // reset mid-count
    tick(1, 2'd1, 32'd5);
    tick(1, 2'd0, 32'h9);
    repeat (3) tick(0, 2'd0, 32'd0);
    do_reset();
    repeat (8) tick(0, 2'd0, 32'd0);
    chk("post_reset_count", obs[2], 32'd0);

    // one-shot
    tick(1, 2'd1, 32'd4);
    tick(1, 2'd0, 32'h9);
    wait_irq(40, n);
    chk("oneshot_lat", 32'(n), 32'd6);
    tick(0, 2'd0, 32'd0);
    chk("oneshot_ctrl", obs[0], 32'h8);
    repeat (20) tick(0, 2'd0, 32'd0);
    chk("oneshot_hold", {31'd0, obs_irq}, 32'd1);
    tick(1, 2'd0, 32'h8);
    chk("oneshot_clear", {31'd0, obs_irq}, 32'd0);

    // periodic
    tick(1, 2'd1, 32'd3);
    tick(1, 2'd0, 32'hB);
    wait_irq(40, n);
    chk("per_lat", 32'(n), 32'd5);
    for (int p = 0; p < 4; p++) begin
      tick(0, 2'd0, 32'd0);
      chk("per_width", {31'd0, obs_irq}, 32'd0);
      wait_irq(40, n);
      chk("per_gap", 32'(n + 1), 32'd5);
    end
    tick(1, 2'd0, 32'h0);
    tick(0, 2'd0, 32'd0);

    // mask
    tick(1, 2'd1, 32'd2);
    tick(1, 2'd0, 32'h1);
    repeat (10) tick(0, 2'd0, 32'd0);
    tick(1, 2'd0, 32'h8);
    tick(0, 2'd0, 32'd0);
    chk("mask_irq", {31'd0, obs_irq}, 32'd0);

    // PRESET=0 behaves as one count
    tick(1, 2'd1, 32'd0);
    tick(1, 2'd0, 32'h9);
    wait_irq(40, n);
    chk("zero_lat", 32'(n), 32'd3);

    // disable mid-count and restart from PRESET
    tick(1, 2'd1, 32'd20);
    tick(1, 2'd0, 32'h1);
    n = 0;
    do begin tick(0, 2'd0, 32'd0); n++; end while (obs[2] != 32'd8 && n < 40);
    tick(1, 2'd0, 32'h0);
    repeat (3) tick(0, 2'd0, 32'd0);
    chk("freeze", obs[2], 32'd7);
    tick(1, 2'd0, 32'h1);
    repeat (2) tick(0, 2'd0, 32'd0);
    chk("restart", obs[2], 32'd20);

    // PRESET change mid-run applies at next reload
    tick(1, 2'd1, 32'd3);
    tick(1, 2'd0, 32'hB);
    repeat (2) tick(0, 2'd0, 32'd0);
    tick(1, 2'd1, 32'd9);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick(0, 2'd0, 32'd0);
      if (obs[2] == 32'd9) hit = 1;
    end
    chk("reload9", {31'd0, hit}, 32'd1);

    // decode
    tick(1, 2'd0, 32'h0);
    tick(0, 2'd0, 32'd0);
    tick(1, 2'd2, 32'h1234);
    tick(1, 2'd3, 32'h1234);
    chk("rsvd_read", obs[3], 32'd0);
    tick(1, 2'd0, 32'hFFFF_FFFF);
    chk("ctrl_mask", obs[0], 32'hF);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 15));
      if ($urandom_range(0, 399) == 0) do_reset();
      else if (r == 0) tick(1, 2'd0, $urandom);
      else if (r == 1) tick(1, 2'd1, 32'($urandom_range(0, 6)));
      else if (r == 2) tick(1, 2'($urandom_range(2, 3)), $urandom);
      else tick(0, 2'($urandom_range(0, 3)), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
